uart_tx_sched: RTL



---
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin byte scheduler and sole writer of the UART control register
module uart_tx_sched #(
    parameter int         NUM_REQ       = 4,
    parameter int         TX_BUSY_BIT   = 0,
    parameter int         START_TIMEOUT = 1024,
    parameter logic [9:0] CFG_DEFAULT   = 10'h1C3
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*8-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       cfg_valid,
    input  logic [9:0]                 cfg_data,
    output logic                       cfg_ready,
    output logic                       ctl_reg_we,
    output logic [18:0]                ctl_reg_wdata,
    output logic [18:0]                ctl_reg_wmask,
    input  logic [11:0]                st_reg_rdata,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       err_timeout,
    input  logic                       err_clr,
    output logic                       busy
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, CFG, LOAD, WAIT_BUSY, WAIT_DONE, CLEAR} state_t;

    state_t        state, nxt;
    logic [IW-1:0] last_grant, cur_id, gnt, idx;
    logic          gnt_any, tx_busy, timeout, unused_ok;
    logic [9:0]    shadow;
    logic [15:0]   cnt;

    assign tx_busy   = st_reg_rdata[TX_BUSY_BIT];
    assign unused_ok = ^st_reg_rdata;
    assign busy      = state != IDLE;
    assign timeout   = state == WAIT_BUSY && !tx_busy && cnt == 16'(START_TIMEOUT - 1);

    // Round-robin search starting just after the last winner; the nearest valid requester wins
    always_comb begin
        gnt_any = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(last_grant) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt     = idx;
            end
        end
    end

    // Next state and handshakes; config always beats byte requests in IDLE
    always_comb begin
        nxt       = state;
        cfg_ready = 1'b0;
        req_ready = '0;
        case (state)
            IDLE: begin
                if (cfg_valid) begin
                    cfg_ready = 1'b1;
                    nxt       = CFG;
                end else if (gnt_any) begin
                    req_ready = NUM_REQ'(1) << gnt;
                    nxt       = LOAD;
                end
            end
            CFG:       nxt = IDLE;
            LOAD:      nxt = WAIT_BUSY;
            WAIT_BUSY: nxt = tx_busy ? WAIT_DONE : (timeout ? CLEAR : WAIT_BUSY);
            WAIT_DONE: nxt = tx_busy ? WAIT_DONE : CLEAR;
            CLEAR:     nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= nxt;
    end

    // Register the write port from the next state so the strobe lines up with CFG/LOAD/CLEAR
    always_ff @(posedge clk) begin
        if (srst) begin
            shadow        <= CFG_DEFAULT;
            last_grant    <= IW'(NUM_REQ - 1);
            cur_id        <= '0;
            cnt           <= '0;
            ctl_reg_we    <= 1'b0;
            ctl_reg_wdata <= '0;
            ctl_reg_wmask <= '0;
            done          <= 1'b0;
            done_id       <= '0;
            err_timeout   <= 1'b0;
        end else begin
            ctl_reg_we    <= nxt inside {CFG, LOAD, CLEAR};
            ctl_reg_wdata <= '0;
            ctl_reg_wmask <= '0;
            done          <= nxt == CLEAR;
            cnt           <= state == WAIT_BUSY ? cnt + 16'd1 : 16'd0;
            err_timeout   <= timeout | (err_timeout & ~err_clr);
            if (cfg_ready) begin
                shadow        <= cfg_data;
                ctl_reg_wdata <= {9'h0, cfg_data};
                ctl_reg_wmask <= 19'h003FF;
            end
            if (|req_ready) begin
                cur_id        <= gnt;
                last_grant    <= gnt;
                ctl_reg_wdata <= {req_data[{gnt, 3'b000} +: 8], 1'b1, shadow[9:1], 1'b1};
                ctl_reg_wmask <= 19'h7FC01;
            end
            if (nxt == CLEAR) begin
                ctl_reg_wmask <= 19'h00400;
                done_id       <= cur_id;
            end
        end
    end
endmodule
